pd_switch_responder: RTL and testbench

Domain-side responder to the power manager's sleep sequencing outputs (isolation, state-retention and power-switch enables). It executes the gating request as a staggered, segment-by-segment switch sequence to limit rush current, and returns a `power_ack` when the domain is fully off. It forces isolation whenever any segment is unpowered and holds retention across the off period. It also checks enable ordering and flags protocol violations. It sits at the boundary of each switchable domain, one instance per domain.

---
 rtl/pd_pkg.sv | 22 ++
 rtl/pd_seg_timer.sv | 31 +++
 rtl/pd_switch_responder.sv | 148 ++++++++++++++
 tb/tb_pd_switch_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared definitions for domain power-switch sequencing: FSM state encoding
// and protocol-violation codes.
package pd_pkg;

    localparam logic [2:0] PD_ON       = 3'd0;
    localparam logic [2:0] PD_GATING   = 3'd1;
    localparam logic [2:0] PD_OFF      = 3'd2;
    localparam logic [2:0] PD_UNGATING = 3'd3;

    typedef enum logic [2:0] {
        ST_ON       = PD_ON,
        ST_GATING   = PD_GATING,
        ST_OFF      = PD_OFF,
        ST_UNGATING = PD_UNGATING
    } pd_state_e;

    localparam logic [1:0] VIOL_NONE           = 2'd0;
    localparam logic [1:0] VIOL_SW_NO_RET      = 2'd1;
    localparam logic [1:0] VIOL_RET_NO_ISO     = 2'd2;
    localparam logic [1:0] VIOL_DROP_WHILE_OFF = 2'd3;

endpackage

// File: rtl/pd_seg_timer.sv
// Loadable down-counter pacing segment transitions: load sets SEG_DELAY-1,
// then it counts down and parks at 0, where expired is asserted.
module pd_seg_timer #(
    parameter int unsigned SEG_DELAY = 6,
    localparam int unsigned TW = $clog2(SEG_DELAY + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam logic [TW-1:0] LOAD_VAL = TW'(SEG_DELAY - 1);

    logic [TW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/pd_switch_responder.sv
// Domain-side power-switch responder: staggered segment gating/ungating,
// forced isolation, retention hold and enable-ordering checker.
module pd_switch_responder
    import pd_pkg::*;
#(
    parameter int unsigned SEGMENTS  = 4,
    parameter int unsigned SEG_DELAY = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iso_en_in,
    input  logic                ret_en_in,
    input  logic                sw_en_in,
    output logic [SEGMENTS-1:0] seg_off,
    output logic                power_ack,
    output logic                iso_out,
    output logic                ret_out,
    output logic                violation,
    output logic [1:0]          viol_code,
    output logic [2:0]          state
);

    pd_state_e           r_state;
    logic [SEGMENTS-1:0] r_seg_off;
    logic                r_power_ack;
    logic                r_ret_out;
    logic                r_violation;
    logic [1:0]          r_viol_code;
    logic                r_iso_d;
    logic                r_ret_d;
    logic                r_sw_d;

    logic                w_expired;
    logic                w_load;
    logic                w_all_off;
    logic                w_all_on;
    logic [SEGMENTS-1:0] w_seg_more;
    logic [SEGMENTS-1:0] w_seg_less;

    // Segments always form a thermometer from bit 0, so "set lowest clear" is a
    // left shift in of 1 and "clear highest set" is a right shift.
    assign w_seg_more = (r_seg_off << 1) | SEGMENTS'(1);
    assign w_seg_less = r_seg_off >> 1;
    assign w_all_off  = &r_seg_off;
    assign w_all_on   = (r_seg_off == '0);

    assign w_load = ((r_state == ST_ON)       &&  sw_en_in)
                 || ((r_state == ST_GATING)   && (!sw_en_in || (w_expired && !w_all_off)))
                 || ((r_state == ST_OFF)      && !sw_en_in)
                 || ((r_state == ST_UNGATING) && ( sw_en_in || (w_expired && !w_all_on)));

    pd_seg_timer #(.SEG_DELAY(SEG_DELAY)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ON;
            r_seg_off   <= '0;
            r_power_ack <= 1'b0;
            r_ret_out   <= 1'b0;
        end else begin
            r_ret_out <= (r_state == ST_ON) ? ret_en_in : 1'b1;
            case (r_state)
                ST_ON: begin
                    if (sw_en_in) begin
                        r_state   <= ST_GATING;
                        r_seg_off <= w_seg_more;
                    end
                end
                ST_GATING: begin
                    // An abort outranks a simultaneous timer expiry.
                    if (!sw_en_in) begin
                        r_state   <= ST_UNGATING;
                        r_seg_off <= w_seg_less;
                    end else if (w_expired) begin
                        if (w_all_off) begin
                            r_state     <= ST_OFF;
                            r_power_ack <= 1'b1;
                        end else begin
                            r_seg_off <= w_seg_more;
                        end
                    end
                end
                ST_OFF: begin
                    if (!sw_en_in) begin
                        r_state     <= ST_UNGATING;
                        r_power_ack <= 1'b0;
                        r_seg_off   <= w_seg_less;
                    end
                end
                ST_UNGATING: begin
                    if (sw_en_in) begin
                        r_state   <= ST_GATING;
                        r_seg_off <= w_seg_more;
                    end else if (w_expired) begin
                        if (w_all_on) begin
                            r_state <= ST_ON;
                        end else begin
                            r_seg_off <= w_seg_less;
                        end
                    end
                end
                default: r_state <= ST_ON;
            endcase
        end
    end

    // Ordering checker: edges come from registered previous input values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iso_d     <= 1'b0;
            r_ret_d     <= 1'b0;
            r_sw_d      <= 1'b0;
            r_violation <= 1'b0;
            r_viol_code <= VIOL_NONE;
        end else begin
            r_iso_d <= iso_en_in;
            r_ret_d <= ret_en_in;
            r_sw_d  <= sw_en_in;
            if (!r_violation) begin
                if (sw_en_in && !r_sw_d && (!ret_en_in || !iso_en_in)) begin
                    r_violation <= 1'b1;
                    r_viol_code <= VIOL_SW_NO_RET;
                end else if (ret_en_in && !r_ret_d && !iso_en_in) begin
                    r_violation <= 1'b1;
                    r_viol_code <= VIOL_RET_NO_ISO;
                end else if (((!iso_en_in && r_iso_d) || (!ret_en_in && r_ret_d))
                             && (r_state != ST_ON)) begin
                    r_violation <= 1'b1;
                    r_viol_code <= VIOL_DROP_WHILE_OFF;
                end
            end
        end
    end

    assign seg_off   = r_seg_off;
    assign power_ack = r_power_ack;
    assign iso_out   = iso_en_in | (|r_seg_off);
    assign ret_out   = r_ret_out;
    assign violation = r_violation;
    assign viol_code = r_viol_code;
    assign state     = r_state;

endmodule

// File: tb/tb_pd_switch_responder.sv
// Directed bench for pd_switch_responder: sleep, wake, abort, ordering
// violations and asynchronous reset mid-sequence.
module tb_pd_switch_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       iso_en_in;
    logic       ret_en_in;
    logic       sw_en_in;
    logic [3:0] seg_off;
    logic       power_ack;
    logic       iso_out;
    logic       ret_out;
    logic       violation;
    logic [1:0] viol_code;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    pd_switch_responder #(.SEGMENTS(4), .SEG_DELAY(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .iso_en_in (iso_en_in),
        .ret_en_in (ret_en_in),
        .sw_en_in  (sw_en_in),
        .seg_off   (seg_off),
        .power_ack (power_ack),
        .iso_out   (iso_out),
        .ret_out   (ret_out),
        .violation (violation),
        .viol_code (viol_code),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; iso_en_in = 1'b0; ret_en_in = 1'b0; sw_en_in = 1'b0;
        edges(2);
        check("rst_state", state, 0);
        check("rst_seg", seg_off, 4'b0000);
        check("rst_ack", power_ack, 0);
        check("rst_ret", ret_out, 0);
        check("rst_viol", violation, 0);
        check("rst_code", viol_code, 0);
        check("rst_iso0", iso_out, 0);
        iso_en_in = 1'b1; #1;
        check("rst_iso1", iso_out, 1);
        reset = 1'b0;

        // Legal sleep
        edges(1); ret_en_in = 1'b1;
        edges(1); sw_en_in = 1'b1;
        edges(1);
        check("slp_e0_seg", seg_off, 4'b0001);
        check("slp_e0_state", state, 1);
        edges(6);  check("slp_e6_seg", seg_off, 4'b0011);
        edges(6);  check("slp_e12_seg", seg_off, 4'b0111);
        edges(6);  check("slp_e18_seg", seg_off, 4'b1111);
        edges(5);  check("slp_e23_ack", power_ack, 0);
        check("slp_e23_state", state, 1);
        edges(1);  check("slp_e24_ack", power_ack, 1);
        check("slp_e24_state", state, 2);
        check("slp_viol", violation, 0);
        check("slp_ret", ret_out, 1);

        // Wake
        sw_en_in = 1'b0;
        edges(1);
        check("wk_e0_ack", power_ack, 0);
        check("wk_e0_seg", seg_off, 4'b0111);
        check("wk_e0_state", state, 3);
        edges(6);  check("wk_e6_seg", seg_off, 4'b0011);
        edges(6);  check("wk_e12_seg", seg_off, 4'b0001);
        edges(6);  check("wk_e18_seg", seg_off, 4'b0000);
        check("wk_e18_ret", ret_out, 1);
        check("wk_e18_state", state, 3);
        edges(6);  check("wk_e24_state", state, 0);
        ret_en_in = 1'b0;
        edges(1);  edges(1);
        check("wk_ret_follow", ret_out, 0);
        iso_en_in = 1'b0; #1;
        check("wk_iso_rel", iso_out, 0);
        check("wk_viol", violation, 0);

        // Abort during gating at E0+8
        edges(1); iso_en_in = 1'b1;
        edges(1); ret_en_in = 1'b1;
        edges(1); sw_en_in = 1'b1;
        edges(1);  check("ab_e0_seg", seg_off, 4'b0001);
        edges(6);  check("ab_e6_seg", seg_off, 4'b0011);
        edges(1);  sw_en_in = 1'b0;
        edges(1);  check("ab_e8_seg", seg_off, 4'b0001);
        check("ab_e8_state", state, 3);
        edges(5);  check("ab_e13_seg", seg_off, 4'b0001);
        edges(1);  check("ab_e14_seg", seg_off, 4'b0000);
        edges(5);  check("ab_e19_state", state, 3);
        edges(1);  check("ab_e20_state", state, 0);
        check("ab_viol", violation, 0);

        // sw rises without retention: violation 1, gating still completes
        ret_en_in = 1'b0;
        edges(1); sw_en_in = 1'b1;
        edges(1);
        check("v1_flag", violation, 1);
        check("v1_code", viol_code, 1);
        check("v1_seg", seg_off, 4'b0001);
        edges(23); check("v1_e23_state", state, 1);
        edges(1);  check("v1_e24_state", state, 2);
        check("v1_e24_ack", power_ack, 1);
        #2 reset = 1'b1; #1;
        check("v1_rst_seg", seg_off, 4'b0000);
        check("v1_rst_viol", violation, 0);
        sw_en_in = 1'b0; ret_en_in = 1'b0; iso_en_in = 1'b0;
        edges(1); reset = 1'b0;

        // Asynchronous reset mid-gating
        edges(1); iso_en_in = 1'b1;
        edges(1); ret_en_in = 1'b1;
        edges(1); sw_en_in = 1'b1;
        edges(1);  check("mr_e0_seg", seg_off, 4'b0001);
        edges(12); check("mr_e12_seg", seg_off, 4'b0111);
        #2 reset = 1'b1; #1;
        check("mr_seg", seg_off, 4'b0000);
        check("mr_state", state, 0);
        check("mr_ack", power_ack, 0);
        sw_en_in = 1'b0;
        edges(2); reset = 1'b0;
        edges(1); sw_en_in = 1'b1;
        edges(1);  check("mr_resume_seg", seg_off, 4'b0001);
        check("mr_resume_state", state, 1);
        edges(24); check("mr_off_state", state, 2);
        check("mr_off_ack", power_ack, 1);

        // Isolation dropped while OFF
        iso_en_in = 1'b0; #1;
        check("v3_iso_held", iso_out, 1);
        edges(1);
        check("v3_flag", violation, 1);
        check("v3_code", viol_code, 3);
        check("v3_iso_after", iso_out, 1);
        check("v3_state", state, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
